div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Iterative radix-2 restoring divider in the EX stage. Executes the DIV/DIVU ALU controls.
//  EX asserts start with the operands; the divider runs for multiple cycles while EX stalls.
//  It then returns the quotient and remainder to the HI/LO write path.
//  Signed or unsigned division is selected per operation. A pipeline flush aborts an operation in flight.
// PARAMETERS
//  DATA_W  32  operand/result width; iteration count = DATA_W
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       request; sampled only when ready=1
//  is_signed  in   1       1=DIV (two's complement), 0=DIVU; sampled with start
//  a          in   DATA_W  dividend; sampled with start
//  b          in   DATA_W  divisor; sampled with start
//  cancel     in   1       flush; aborts any operation, highest priority
//  ready      out  1       1 when state==IDLE (combinational from state)
//  busy       out  1       ~ready; EX uses it as the stall request
//  valid      out  1       one-cycle pulse: quotient/remainder are new
//  quotient   out  DATA_W  registered; held until the next valid
//  remainder  out  DATA_W  registered; held until the next valid
// BEHAVIOUR
//  - One clock domain: clk. Reset: rst is asynchronous and active-high.
//  - Reset: state=IDLE, counter=0, valid=0, quotient=0, remainder=0; ready=1, busy=0.
//  - States: IDLE, CALC, POST.
//  - IDLE -> CALC on start & ~cancel:
//    - latch |a| and |b| (magnitude only if is_signed);
//    - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both 0 if unsigned);
//    - latch div0 = (b==0); clear partial remainder and counter.
//  - CALC, one iteration per cycle:
//    - shift {rem,quo} left 1; trial = rem - |b| at DATA_W+1 bits;
//    - if trial is non-negative: rem = trial, quo[0] = 1; else quo[0] = 0.
//  - CALC -> POST after the iteration with counter==DATA_W-1.
//  - POST: register results, set valid=1, then -> IDLE.
//    - quotient  = sign_q ? -quo : quo;
//    - remainder = sign_r ? -rem : rem (the remainder takes the dividend's sign).
//  - Latency: start sampled at edge 0; edges 1..DATA_W iterate; edge DATA_W+1 registers outputs.
//    valid is high from edge DATA_W+1 to edge DATA_W+2 (33/34 for 32-bit).
//  - Divide by zero (div0):
//    - full latency still applies;
//    - quotient = all ones and remainder = a, sign fixup bypassed;
//    - no exception is raised.
//  - Signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0; the wrap is allowed.
//  - start while busy is ignored; operands are not re-sampled.
//  - cancel in any state: next state=IDLE and valid=0.
//    quotient/remainder keep their previous values; no valid is produced for the aborted operation.
//  - cancel and start in the same IDLE cycle: cancel wins, nothing is accepted.
//  - start in the cycle valid is high (state IDLE): accepted, back-to-back.
//  - rst mid-operation: immediate return to the reset values; no valid.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//   - at the start edge, if b!=0 and |a|<|b| (this includes a==0): skip CALC and go to POST;
//   - quo=0 and rem=|a|, so after fixup quotient=0 and remainder=a;
//   - valid is high from edge 1 to edge 2.
//  DIV_EARLY_OUT_EN undefined:
//   - every operation takes the full DATA_W+1 cycle latency; no magnitude pre-compare logic.
// TESTING
//  1 DIVU a=100 b=7 -> valid at edge 33 only; quotient=14, remainder=2; busy high edges 0..32.
//  2 DIV a=-7 (0xFFFFFFF9) b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
//  3 DIV a=0x80000000 b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//    DIVU a=5 b=0 -> quotient=0xFFFFFFFF, remainder=5.
//  4 start DIVU 100/7, cancel at edge 10 -> IDLE at edge 11, no valid, outputs keep old values.
//    A new start at edge 12 gives valid at edge 45.
//  5 start with a second start at edge 5 -> second ignored.
//    start held at the valid edge -> back-to-back result 33 cycles later.
//    rst pulse mid-CALC -> outputs 0, ready=1.
//  6 DIV_EARLY_OUT_EN: DIVU a=3 b=9 -> valid at edge 1, quotient=0, remainder=3.
//    Without the macro: valid at edge 33, same values.

Source files
------------

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - request/result bundle between the EX stage and the iterative divider
interface div_iter_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cancel;
  logic              ready;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output start, is_signed, a, b, cancel,
    input  ready, busy, valid, quotient, remainder
  );

  modport slave (
    input  start, is_signed, a, b, cancel,
    output ready, busy, valid, quotient, remainder
  );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle
// Optional early out for |a|<|b| enabled by defining DIV_EARLY_OUT_EN.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    POST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              early;

  always_comb begin
    a_mag   = (bus.is_signed && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    b_mag   = (bus.is_signed && bus.b[DATA_W-1]) ? -bus.b : bus.b;
    // Trial subtraction is one bit wider so its MSB is the borrow.
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    // With a zero divisor rem ends as |a|, so this also restores the raw dividend.
    rem_fix = neg_rem_q ? -rem_q : rem_q;
`ifdef DIV_EARLY_OUT_EN
    early   = (bus.b != '0) && (a_mag < b_mag);
`else
    early   = 1'b0;
`endif

    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    div0_d      = div0_q;
    valid_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = early ? POST : CALC;
          rem_d     = early ? a_mag : '0;
          quo_d     = early ? '0 : a_mag;
          dvs_d     = b_mag;
          neg_quo_d = bus.is_signed & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
          neg_rem_d = bus.is_signed & bus.a[DATA_W-1];
          div0_d    = (bus.b == '0);
          cnt_d     = '0;
        end
      end
      CALC: begin
        rem_d = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = POST;
        end
      end
      POST: begin
        valid_d     = 1'b1;
        quotient_d  = div0_q ? '1 : quo_fix;
        remainder_d = rem_fix;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush beats everything, including a result about to be registered.
    if (bus.cancel) begin
      state_d     = IDLE;
      valid_d     = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      valid_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      div0_q      <= div0_d;
      valid_q     <= valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.valid     = valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule
